pdm_capture_ctrl: RTL

Controller that sequences the PDM microphone datapath and its 16-bit sample output. It gates the mic datapath on and off, discards samples during the microphone's power-up settle period, and decimates the sample stream by a runtime ratio. Kept samples are buffered in a small FIFO and handed to a downstream consumer (audio bus/host bridge) over a valid/ready interface.

---
 rtl/pdm_ctrl_pkg.sv | 16 +
 rtl/pdm_capture_ctrl_if.sv | 14 +
 rtl/sample_fifo.sv | 64 ++++++
 rtl/pdm_capture_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/pdm_ctrl_pkg.sv
// Shared definitions for the PDM capture controller.
//   state_e   : FSM state encoding (value 3 is unused and recovers to IDLE)
//   cnt_width : bits needed to count from 0 up to and including n
package pdm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pdm_capture_ctrl_if.sv
// Sample stream from the capture controller to the downstream consumer.
//   out_data  : signed FIFO head (first-word-fall-through)
//   out_valid : FIFO non-empty
//   out_ready : consumer accepts the head this cycle
interface pdm_capture_ctrl_if #(
  parameter int SAMPLE_DEPTH = 16
);
  logic signed [SAMPLE_DEPTH-1:0] out_data;
  logic                           out_valid;
  logic                           out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst  : clock, synchronous active-high reset
//   flush     : empties the FIFO next cycle; same-cycle push/pop discarded
//   push/push_data : write request; accepted when not full, or when full
//                    and a pop happens in the same cycle
//   pop       : read request, ignored while empty
//   head/valid: current head word and non-empty flag
//   full/level: full flag and occupancy
module sample_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // addresses with differing wrap bits mean full.
  always_comb begin
    valid    = (wr_ptr_q != rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    level    = wr_ptr_q - rd_ptr_q;
    head     = mem_q[rd_ptr_q[AW-1:0]];
    do_pop   = pop && valid && !flush;
    do_push  = push && (!full || do_pop) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/pdm_capture_ctrl.sv
// PDM microphone capture controller: gates the mic datapath, discards the
// power-up settle samples, decimates the strobe stream and buffers kept
// samples in an output FIFO.
//   clk, rst           : clock, synchronous active-high reset
//   enable             : capture request level
//   decim_ratio        : keep 1 of every decim_ratio+1 strobes (latched on start)
//   flush, overflow_clr: single-cycle pulses
//   pdm_rst, mic_clk_en: mic datapath controls (lag the FSM state by a cycle)
//   sample_in/stb      : incoming samples
//   out_if             : valid/ready sample stream
//   overflow           : sticky dropped-sample flag
//   state, fifo_level  : status
module pdm_capture_ctrl
  import pdm_ctrl_pkg::*;
#(
  parameter int SAMPLE_DEPTH   = 16,
  parameter int SETTLE_SAMPLES = 4096,
  parameter int DECIM_W        = 8,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [DECIM_W-1:0]             decim_ratio,
  input  logic                           flush,
  input  logic                           overflow_clr,
  output logic                           pdm_rst,
  output logic                           mic_clk_en,
  input  logic signed [SAMPLE_DEPTH-1:0] sample_in,
  input  logic                           sample_stb,
  pdm_capture_ctrl_if.master             out_if,
  output logic                           overflow,
  output logic [1:0]                     state,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

  localparam int SW = cnt_width(SETTLE_SAMPLES);

  logic [1:0]         state_q, state_d;
  logic [DECIM_W-1:0] ratio_q, ratio_d;
  logic [DECIM_W-1:0] decim_cnt_q, decim_cnt_d;
  logic [SW-1:0]      settle_cnt_q, settle_cnt_d;
  logic               pdm_rst_q, pdm_rst_d;
  logic               mic_clk_en_q, mic_clk_en_d;
  logic               overflow_q, overflow_d;
  logic               push, fifo_full, fifo_valid, ovf_set;
  logic [SAMPLE_DEPTH-1:0] fifo_head;

  always_comb begin
    state_d      = state_q;
    ratio_d      = ratio_q;
    decim_cnt_d  = decim_cnt_q;
    settle_cnt_d = settle_cnt_q;
    push         = 1'b0;
    case (state_q)
      ST_IDLE: if (enable) begin
        state_d      = ST_SETTLE;
        ratio_d      = decim_ratio;
        settle_cnt_d = '0;
        decim_cnt_d  = '0;
      end
      ST_SETTLE: begin
        if (!enable) state_d = ST_IDLE;
        else if (sample_stb) begin
          settle_cnt_d = settle_cnt_q + 1'b1;
          if (settle_cnt_q == SW'(SETTLE_SAMPLES - 1)) begin
            state_d     = ST_RUN;
            // Preload so the very first strobe in RUN is kept.
            decim_cnt_d = ratio_q;
          end
        end
      end
      ST_RUN: begin
        if (!enable) state_d = ST_IDLE;
        else if (sample_stb) begin
          if (decim_cnt_q == ratio_q) begin
            push        = 1'b1;
            decim_cnt_d = '0;
          end else begin
            decim_cnt_d = decim_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Mic controls follow the registered state, so they trail it by a cycle.
    mic_clk_en_d = (state_q == ST_SETTLE) || (state_q == ST_RUN);
    pdm_rst_d    = !mic_clk_en_d;

    // Drop only when full with no pop to make room; a flush discards the push.
    ovf_set    = push && fifo_full && !(fifo_valid && out_if.out_ready) && !flush;
    overflow_d = ovf_set ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ratio_q      <= '0;
      decim_cnt_q  <= '0;
      settle_cnt_q <= '0;
      pdm_rst_q    <= 1'b1;
      mic_clk_en_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ratio_q      <= ratio_d;
      decim_cnt_q  <= decim_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      pdm_rst_q    <= pdm_rst_d;
      mic_clk_en_q <= mic_clk_en_d;
      overflow_q   <= overflow_d;
    end
  end

  sample_fifo #(.WIDTH(SAMPLE_DEPTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (sample_in),
    .pop       (out_if.out_ready),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  assign out_if.out_data  = fifo_head;
  assign out_if.out_valid = fifo_valid;
  assign pdm_rst          = pdm_rst_q;
  assign mic_clk_en       = mic_clk_en_q;
  assign overflow         = overflow_q;
  assign state            = state_q;

endmodule
